// File: rtl/fn_sel_detect_pkg.sv
// Shared encodings for the fn_sw selector monitor: FSM states and selector values.
package fn_sel_detect_pkg;

   typedef enum logic [1:0] {
      ST_UNKNOWN = 2'd0,
      ST_TRACK   = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_FAULT   = 2'd3
   } state_e;

   localparam logic SEL_AND = 1'b0;
   localparam logic SEL_XOR = 1'b1;

endpackage

// File: rtl/fn_sel_detect_if.sv
// Sample/status bundle between an fn_sw observer (master) and the selector detector (slave).
interface fn_sel_detect_if;

   logic in_valid;
   logic a;
   logic b;
   logic y;
   logic clr;
   logic sel_est;
   logic sel_lock;
   logic sel_chg;
   logic fault;

   modport master (
      output in_valid, a, b, y, clr,
      input  sel_est, sel_lock, sel_chg, fault
   );

   modport slave (
      input  in_valid, a, b, y, clr,
      output sel_est, sel_lock, sel_chg, fault
   );

endinterface

// File: rtl/fn_sw_classify.sv
// Combinational classification of one fn_sw (a, b, y) sample.
module fn_sw_classify (
   input  logic a,
   input  logic b,
   input  logic y,
   output logic informative,
   output logic illegal,
   output logic ind
);

   // With a=b=0 both functions give 0, so only a|b=1 can tell them apart.
   always_comb begin
      informative = a | b;
      illegal     = ~(a | b) & y;
      ind         = (y == (a ^ b));
   end

endmodule

// File: rtl/fn_sel_detect.sv
// Recovers the fn_sw selector from observed samples; locks after LOCK_CNT consistent samples.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_UNKNOWN | no informative evidence since reset/clear
//   ST_TRACK   | candidate held, collecting consecutive agreeing samples
//   ST_LOCKED  | LOCK_CNT agreeing samples seen, estimate reported locked
//   ST_FAULT   | impossible sample seen; sticky until rst or clr
module fn_sel_detect
   import fn_sel_detect_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 3
) (
   input  logic          clk,
   input  logic          rst,
   fn_sel_detect_if.slave bus
);

   localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

   logic informative;
   logic illegal;
   logic ind;

   fn_sw_classify u_classify (
      .a           (bus.a),
      .b           (bus.b),
      .y           (bus.y),
      .informative (informative),
      .illegal     (illegal),
      .ind         (ind)
   );

   state_e           state_q, state_d;
   logic             cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             sel_chg_q, sel_chg_d;
   logic             sel_lock_q, sel_lock_d;
   logic             fault_q, fault_d;

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      sel_chg_d = 1'b0;
      cnt_inc   = cnt_q + ONE_V;

      if (bus.clr) begin
         state_d = ST_UNKNOWN;
         cand_d  = SEL_AND;
         cnt_d   = '0;
      end else if (bus.in_valid && state_q != ST_FAULT) begin
         if (illegal) begin
            state_d = ST_FAULT;
         end else if (informative) begin
            case (state_q)
               ST_UNKNOWN: begin
                  cand_d  = ind;
                  cnt_d   = ONE_V;
                  state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_TRACK;
               end
               ST_TRACK: begin
                  if (ind == cand_q) begin
                     cnt_d = cnt_inc;
                     if (cnt_inc == LOCK_V) state_d = ST_LOCKED;
                  end else begin
                     cand_d = ind;
                     cnt_d  = ONE_V;
                  end
               end
               ST_LOCKED: begin
                  // Agreeing samples leave cnt parked at LOCK_CNT.
                  if (ind != cand_q) begin
                     sel_chg_d = 1'b1;
                     cand_d    = ind;
                     cnt_d     = ONE_V;
                     state_d   = (LOCK_CNT == 1) ? ST_LOCKED : ST_TRACK;
                  end
               end
               default: state_d = state_q;
            endcase
         end
      end

      sel_lock_d = (state_d == ST_LOCKED);
      fault_d    = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_UNKNOWN;
         cand_q     <= SEL_AND;
         cnt_q      <= '0;
         sel_chg_q  <= 1'b0;
         sel_lock_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         sel_chg_q  <= sel_chg_d;
         sel_lock_q <= sel_lock_d;
         fault_q    <= fault_d;
      end
   end

   assign bus.sel_est  = cand_q;
   assign bus.sel_lock = sel_lock_q;
   assign bus.sel_chg  = sel_chg_q;
   assign bus.fault    = fault_q;

endmodule

// File: tb/tb_fn_sel_detect.sv
// Scoreboard bench for fn_sel_detect: driver feeds fn_sw-generated samples, monitor compares.
module tb_fn_sel_detect;

   localparam int LOCK_CNT = 4;

   logic clk;
   logic rst;

   fn_sel_detect_if sif ();

   fn_sel_detect #(.LOCK_CNT(LOCK_CNT), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit    est;
      bit    lock;
      bit    chg;
      bit    fault;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: evidence as a run length of agreeing informative samples.
   bit m_cand, m_lock, m_chg, m_fault;
   int m_run;

   function automatic bit fn_sw(input bit sel, input bit a_i, input bit b_i);
      return sel ? (a_i ^ b_i) : (a_i & b_i);
   endfunction

   task automatic model(input bit r, input bit c, input bit v,
                        input bit a_i, input bit b_i, input bit y_i);
      bit xor_ok, and_ok;
      m_chg = 1'b0;
      if (r || c) begin
         m_cand = 0; m_run = 0; m_lock = 0; m_fault = 0;
      end else if (v && !m_fault) begin
         xor_ok = (y_i == (a_i ^ b_i));
         and_ok = (y_i == (a_i & b_i));
         if (!xor_ok && !and_ok) begin
            m_fault = 1; m_lock = 0; m_run = 0;
         end else if (xor_ok != and_ok) begin
            if (m_run > 0 && xor_ok == m_cand) m_run++;
            else begin
               if (m_lock) m_chg = 1;
               m_cand = xor_ok;
               m_run  = 1;
            end
            m_lock = (m_run >= LOCK_CNT);
         end
      end
   endtask

   task automatic step(input bit r, input bit c, input bit v,
                       input bit a_i, input bit b_i, input bit y_i, input string tag);
      exp_t e;
      @(negedge clk);
      rst = r; sif.clr = c; sif.in_valid = v;
      sif.a = a_i; sif.b = b_i; sif.y = y_i;
      model(r, c, v, a_i, b_i, y_i);
      e.est = m_cand; e.lock = m_lock; e.chg = m_chg; e.fault = m_fault; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic sw(input bit sel, input bit a_i, input bit b_i, input string tag);
      step(0, 0, 1, a_i, b_i, fn_sw(sel, a_i, b_i), tag);
   endtask

   task automatic check1(input string name, input string tag, input bit act, input bit expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s/%s: got %0b expected %0b at %0t", tag, name, act, expv, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check1("sel_est",  e.tag, sif.sel_est,  e.est);
         check1("sel_lock", e.tag, sif.sel_lock, e.lock);
         check1("sel_chg",  e.tag, sif.sel_chg,  e.chg);
         check1("fault",    e.tag, sif.fault,    e.fault);
      end
   end

   initial begin
      bit sel;
      int waited;
      rst = 1; sif.clr = 0; sif.in_valid = 0; sif.a = 0; sif.b = 0; sif.y = 0;
      m_cand = 0; m_run = 0; m_lock = 0; m_chg = 0; m_fault = 0;

      // reset with samples present
      step(1, 0, 1, 1, 0, 1, "rst");
      step(1, 0, 1, 1, 0, 1, "rst");

      // lock onto XOR
      repeat (4) sw(1, 1, 0, "lock_xor");
      sw(1, 1, 0, "locked_hold");

      // contradiction: (1,1,1) implies AND
      step(0, 0, 1, 1, 1, 1, "chg");
      repeat (3) sw(0, 0, 1, "relock_and");
      step(0, 0, 0, 0, 0, 0, "idle");

      // TRACK with interleaved uninformative and invalid cycles
      step(0, 1, 0, 0, 0, 0, "clr");
      sw(1, 0, 1, "trk");
      step(0, 0, 1, 0, 0, 0, "trk_uninf");
      step(0, 0, 0, 1, 1, 1, "trk_inval");
      sw(1, 1, 0, "trk");
      step(0, 0, 1, 0, 0, 0, "trk_uninf");
      sw(1, 0, 1, "trk");
      step(0, 0, 0, 0, 0, 1, "trk_inval");
      sw(1, 1, 0, "trk_lock");

      // illegal sample, sticky fault, clear
      step(0, 0, 1, 0, 0, 1, "illegal");
      sw(0, 1, 1, "fault_hold");
      sw(1, 1, 0, "fault_hold");
      step(0, 1, 0, 0, 0, 0, "clr_fault");
      step(0, 1, 1, 1, 0, 1, "clr_drop");
      sw(1, 1, 0, "after_clr");
      step(0, 0, 1, 0, 0, 1, "illegal_trk");
      step(0, 1, 0, 0, 0, 0, "clr");

      // reset mid-TRACK, full relock needed
      sw(0, 1, 1, "pre_rst");
      sw(0, 1, 1, "pre_rst");
      step(1, 0, 0, 0, 0, 0, "rst_mid");
      repeat (4) sw(0, 1, 1, "relock");

      // randomized fn_sw traffic with occasional illegal, clr and rst
      sel = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bit ra, rb, rv;
         if ($urandom_range(0, 15) == 0) sel = ~sel;
         ra = 1'($urandom); rb = 1'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0)      step(1, 0, rv, ra, rb, 1'($urandom), "rnd_rst");
         else if ($urandom_range(0, 149) == 0) step(0, 1, rv, ra, rb, 1'($urandom), "rnd_clr");
         else if ($urandom_range(0, 199) == 0) step(0, 0, 1, 0, 0, 1, "rnd_illegal");
         else step(0, 0, rv, ra, rb, fn_sw(sel, ra, rb), "rnd");
      end

      step(0, 0, 0, 0, 0, 0, "drain");
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
